// File: rtl/processor_8085_multicycle.sv
// processor_8085_multicycle
//   Multi-cycle 8085-style core: accumulator, small register file and CY/Z
//   flags. A FETCH/IMM/EXEC/HALT sequencer reads 8-bit instruction bytes from
//   an external instruction memory that has a combinational read port.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset (overrides en)
//   en          1 = advance one sequencer step per cycle, 0 = hold all state
//   instr_addr  instruction-memory address (always the current pc)
//   instr_data  instruction byte read combinationally from instr_addr
//   pc          program counter
//   acc         accumulator
//   cy          carry / borrow flag
//   z           zero flag
//   halted      1 while the core sits in the HALT state
module processor_8085_multicycle #(
  parameter int DATA_W = 8,
  parameter int NREG   = 7,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [PC_W-1:0]   instr_addr,
  input  logic [7:0]        instr_data,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] acc,
  output logic              cy,
  output logic              z,
  output logic              halted
);

  localparam int SW = DATA_W + 1;

  localparam logic [4:0] OP_MOV_AR = 5'b00000;
  localparam logic [4:0] OP_MOV_RA = 5'b00001;
  localparam logic [4:0] OP_ADD    = 5'b00010;
  localparam logic [4:0] OP_ADC    = 5'b00011;
  localparam logic [4:0] OP_SUB    = 5'b00100;
  localparam logic [4:0] OP_ANA    = 5'b00101;
  localparam logic [4:0] OP_ORA    = 5'b00110;
  localparam logic [4:0] OP_XRA    = 5'b00111;
  localparam logic [4:0] OP_INR    = 5'b01000;
  localparam logic [4:0] OP_DCR    = 5'b01001;
  localparam logic [4:0] OP_IMM    = 5'b01010;
  localparam logic [4:0] OP_JMP    = 5'b01011;
  localparam logic [4:0] OP_HLT    = 5'b11111;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_IMM   = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [7:0]        ir_reg;
  logic [7:0]        t_reg;
  logic [PC_W-1:0]   pc_reg;
  logic [DATA_W-1:0] acc_reg;
  logic              cy_reg;
  logic              z_reg;

  logic [DATA_W-1:0] rf_reg [NREG];
  // Read view padded to all 8 encodable indices; missing entries read 0.
  logic [DATA_W-1:0] rf_rd  [8];

  logic fetch_cyc, imm_cyc, exec_cyc;

  logic [4:0]        op;
  logic [2:0]        rsel;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] imm_ext;
  logic [PC_W-1:0]   jump_target;
  logic              needs_imm;

  logic [DATA_W-1:0] exec_acc;
  logic              exec_cy;
  logic              exec_z;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic              jump_take;
  logic [SW-1:0]     sum;

  assign op          = ir_reg[7:3];
  assign rsel        = ir_reg[2:0];
  assign rdata       = rf_rd[rsel];
  assign imm_ext     = DATA_W'(t_reg);
  assign jump_target = PC_W'(t_reg);
  // Opcodes 01010 (MVI/ADI group) and 01011 (jump group) carry an immediate.
  assign needs_imm   = (instr_data[7:4] == 4'b0101);

  // ---------------- sequencer: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- sequencer: next state ----------------
  always_comb begin
    state_next = state_reg;
    if (en) begin
      case (state_reg)
        ST_FETCH: state_next = needs_imm ? ST_IMM : ST_EXEC;
        ST_IMM:   state_next = ST_EXEC;
        ST_EXEC:  state_next = (op == OP_HLT) ? ST_HALT : ST_FETCH;
        ST_HALT:  state_next = ST_HALT;
        default:  state_next = ST_FETCH;
      endcase
    end
  end

  // ---------------- sequencer: outputs ----------------
  always_comb begin
    fetch_cyc = 1'b0;
    imm_cyc   = 1'b0;
    exec_cyc  = 1'b0;
    halted    = 1'b0;
    case (state_reg)
      ST_FETCH: fetch_cyc = en;
      ST_IMM:   imm_cyc   = en;
      ST_EXEC:  exec_cyc  = en;
      ST_HALT:  halted    = 1'b1;
      default:  ;
    endcase
  end

  // ---------------- execute-stage result computation ----------------
  always_comb begin
    exec_acc  = acc_reg;
    exec_cy   = cy_reg;
    exec_z    = z_reg;
    rf_we     = 1'b0;
    rf_wdata  = acc_reg;
    jump_take = 1'b0;
    sum       = '0;
    case (op)
      OP_MOV_AR: exec_acc = rdata;
      OP_MOV_RA: rf_we = 1'b1;
      OP_ADD, OP_ADC: begin
        sum      = SW'(acc_reg) + SW'(rdata) + ((op == OP_ADC) ? SW'(cy_reg) : '0);
        exec_acc = sum[DATA_W-1:0];
        exec_cy  = sum[DATA_W];
        exec_z   = (sum[DATA_W-1:0] == '0);
      end
      OP_SUB: begin
        // Top bit of the widened difference is the borrow (acc < R[r]).
        sum      = SW'(acc_reg) - SW'(rdata);
        exec_acc = sum[DATA_W-1:0];
        exec_cy  = sum[DATA_W];
        exec_z   = (sum[DATA_W-1:0] == '0);
      end
      OP_ANA, OP_ORA, OP_XRA: begin
        if (op == OP_ANA) begin
          exec_acc = acc_reg & rdata;
        end else if (op == OP_ORA) begin
          exec_acc = acc_reg | rdata;
        end else begin
          exec_acc = acc_reg ^ rdata;
        end
        exec_cy = 1'b0;
        exec_z  = (exec_acc == '0);
      end
      OP_INR, OP_DCR: begin
        rf_we    = 1'b1;
        rf_wdata = (op == OP_INR) ? rdata + DATA_W'(1) : rdata - DATA_W'(1);
        exec_z   = (rf_wdata == '0);
      end
      OP_IMM: begin
        if (rsel == 3'd0) begin
          exec_acc = imm_ext;
        end else if (rsel == 3'd1) begin
          sum      = SW'(acc_reg) + SW'(imm_ext);
          exec_acc = sum[DATA_W-1:0];
          exec_cy  = sum[DATA_W];
          exec_z   = (sum[DATA_W-1:0] == '0);
        end
      end
      OP_JMP: begin
        case (rsel)
          3'd0:    jump_take = 1'b1;
          3'd1:    jump_take = z_reg;
          3'd2:    jump_take = ~z_reg;
          3'd3:    jump_take = cy_reg;
          3'd4:    jump_take = ~cy_reg;
          default: jump_take = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  // ---------------- architectural state ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg  <= '0;
      acc_reg <= '0;
      cy_reg  <= 1'b0;
      z_reg   <= 1'b0;
      ir_reg  <= '0;
      t_reg   <= '0;
    end else begin
      if (fetch_cyc) begin
        ir_reg <= instr_data;
        pc_reg <= pc_reg + PC_W'(1);
      end
      if (imm_cyc) begin
        t_reg  <= instr_data;
        pc_reg <= pc_reg + PC_W'(1);
      end
      if (exec_cyc) begin
        acc_reg <= exec_acc;
        cy_reg  <= exec_cy;
        z_reg   <= exec_z;
        if (jump_take) begin
          pc_reg <= jump_target;
        end
      end
    end
  end

  // Register file: only NREG physical entries; writes to absent indices
  // simply match no entry and are dropped.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rf
      if (gi < NREG) begin : g_phys
        always_ff @(posedge clk) begin
          if (rst) begin
            rf_reg[gi] <= '0;
          end else if (exec_cyc && rf_we && (rsel == 3'(gi))) begin
            rf_reg[gi] <= rf_wdata;
          end
        end
        assign rf_rd[gi] = rf_reg[gi];
      end else begin : g_absent
        assign rf_rd[gi] = '0;
      end
    end
  endgenerate

  assign instr_addr = pc_reg;
  assign pc         = pc_reg;
  assign acc        = acc_reg;
  assign cy         = cy_reg;
  assign z          = z_reg;

endmodule

// File: tb/tb_processor_8085_multicycle.sv
// Directed testbench for processor_8085_multicycle: a default-parameter
// instance (8-bit data, 7 regs, 8-bit pc) and a wide instance
// (16-bit data, 8 regs, 10-bit pc), each fed from its own program memory.
module tb_processor_8085_multicycle;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instance
  logic       rst, en;
  logic [7:0] instr_addr, instr_data, pc, acc;
  logic       cy, z, halted;
  logic [7:0] mem [256];
  assign instr_data = mem[instr_addr];

  processor_8085_multicycle dut (
    .clk(clk), .rst(rst), .en(en),
    .instr_addr(instr_addr), .instr_data(instr_data),
    .pc(pc), .acc(acc), .cy(cy), .z(z), .halted(halted)
  );

  // wide instance
  logic        rst2, en2;
  logic [9:0]  instr_addr2, pc2;
  logic [7:0]  instr_data2;
  logic [15:0] acc2;
  logic        cy2, z2, halted2;
  logic [7:0]  mem2 [1024];
  assign instr_data2 = mem2[instr_addr2];

  processor_8085_multicycle #(.DATA_W(16), .NREG(8), .PC_W(10)) dut16 (
    .clk(clk), .rst(rst2), .en(en2),
    .instr_addr(instr_addr2), .instr_data(instr_data2),
    .pc(pc2), .acc(acc2), .cy(cy2), .z(z2), .halted(halted2)
  );

  int checks = 0;
  int failures = 0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Fill program memory with a 2-cycle NOP (opcode 01100).
  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h60;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------
  task automatic test_reset();
    clear_mem();
    mem[0] = 8'h50; mem[1] = 8'hFF;   // MVI A,FF
    mem[2] = 8'h51; mem[3] = 8'h01;   // ADI 01  -> acc 0, cy 1, z 1
    mem[4] = 8'h50; mem[5] = 8'h05;   // MVI A,05 (flags kept)
    mem[6] = 8'h51; mem[7] = 8'h10;   // ADI 10, interrupted in IMM
    do_reset();
    checks++;
    if (pc !== 8'h00 || acc !== 8'h00 || cy !== 1'b0 || z !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL reset_state pc=%h acc=%h cy=%b z=%b h=%b required all zero", pc, acc, cy, z, halted);
    end
    step(9);
    $display("[reset] before abort acc=%h cy=%b z=%b", acc, cy, z);
    checks++;
    if (acc !== 8'h05 || cy !== 1'b1 || z !== 1'b1) begin
      failures++;
      $display("FAIL pre_abort_flags acc=%h cy=%b z=%b required 05 1 1", acc, cy, z);
    end
    step(1);
    checks++;
    if (pc !== 8'h07) begin
      failures++;
      $display("FAIL in_imm_pc pc=%h required 07", pc);
    end
    rst = 1'b1; en = 1'b0;           // reset must win over en=0
    step(1);
    $display("[reset] after abort pc=%h acc=%h cy=%b z=%b h=%b", pc, acc, cy, z, halted);
    checks++;
    if (pc !== 8'h00 || acc !== 8'h00 || cy !== 1'b0 || z !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset pc=%h acc=%h cy=%b z=%b h=%b required all zero", pc, acc, cy, z, halted);
    end
    rst = 1'b0; en = 1'b1;
    step(3);
    checks++;
    if (pc !== 8'h02 || acc !== 8'hFF || cy !== 1'b0 || z !== 1'b0) begin
      failures++;
      $display("FAIL restart pc=%h acc=%h cy=%b z=%b required 02 FF 0 0", pc, acc, cy, z);
    end
  endtask

  // ---------------------------------------------------------------
  task automatic test_add_chain();
    clear_mem();
    for (int k = 0; k < 7; k++) begin
      mem[3*k]   = 8'h50;            // MVI A,k+1
      mem[3*k+1] = 8'(k + 1);
      mem[3*k+2] = 8'(8'h08 | k);    // MOV rk,A
    end
    mem[21] = 8'h50; mem[22] = 8'h00; // MVI A,0
    for (int k = 0; k < 7; k++) mem[23+k] = 8'(8'h10 | k);  // ADD rk
    mem[30] = 8'h0F;                  // MOV r7,A (dropped)
    mem[31] = 8'h07;                  // MOV A,r7 (reads 0)
    mem[32] = 8'hF8;                  // HLT
    do_reset();
    step(52);
    $display("[add] after ADD chain acc=%h cy=%b z=%b", acc, cy, z);
    checks++;
    if (acc !== 8'd28 || cy !== 1'b0 || z !== 1'b0) begin
      failures++;
      $display("FAIL add_sum acc=%h cy=%b z=%b required 1c 0 0", acc, cy, z);
    end
    step(4);
    checks++;
    if (acc !== 8'h00 || z !== 1'b0 || cy !== 1'b0) begin
      failures++;
      $display("FAIL absent_reg acc=%h cy=%b z=%b required 00 0 0", acc, cy, z);
    end
    step(1);
    checks++;
    if (halted !== 1'b0) begin
      failures++;
      $display("FAIL halt_early halted=%b required 0", halted);
    end
    step(1);
    checks++;
    if (halted !== 1'b1 || pc !== 8'd33) begin
      failures++;
      $display("FAIL halt_entry halted=%b pc=%h required 1 21", halted, pc);
    end
    step(5);
    $display("[add] halted=%b pc=%h", halted, pc);
    checks++;
    if (halted !== 1'b1 || pc !== 8'd33 || acc !== 8'h00) begin
      failures++;
      $display("FAIL halt_hold halted=%b pc=%h acc=%h required 1 21 00", halted, pc, acc);
    end
  endtask

  // ---------------------------------------------------------------
  task automatic test_alu();
    logic [7:0] prog [21];
    logic [7:0] ea [13];
    logic       ec [13];
    logic       ez [13];
    prog = '{8'h50, 8'h07, 8'h0E, 8'h50, 8'hF0, 8'h51, 8'h20,
             8'h26, 8'h26, 8'h26, 8'h1E, 8'h2E, 8'h3E, 8'h36,
             8'h3E, 8'h06, 8'h46, 8'h06, 8'h4D, 8'h05, 8'hF8};
    //       SUB   SUB   SUB   ADC   ANA   XRA   ORA   XRA   MOV   INR   MOV   DCR r5 MOV A,r5
    ea = '{8'h09, 8'h02, 8'hFB, 8'h03, 8'h03, 8'h04, 8'h07, 8'h00, 8'h07, 8'h07, 8'h08, 8'h08, 8'hFF};
    ec = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0};
    ez = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0};
    clear_mem();
    for (int i = 0; i < 21; i++) mem[i] = prog[i];
    do_reset();
    step(8);
    checks++;
    if (acc !== 8'hF0) begin
      failures++;
      $display("FAIL mvi acc=%h required f0", acc);
    end
    step(3);
    $display("[alu] ADI acc=%h cy=%b z=%b", acc, cy, z);
    checks++;
    if (acc !== 8'h10 || cy !== 1'b1 || z !== 1'b0) begin
      failures++;
      $display("FAIL adi_carry acc=%h cy=%b z=%b required 10 1 0", acc, cy, z);
    end
    for (int i = 0; i < 13; i++) begin
      step(2);
      $display("[alu] op %0d acc=%h cy=%b z=%b", i, acc, cy, z);
      checks++;
      if (acc !== ea[i] || cy !== ec[i] || z !== ez[i]) begin
        failures++;
        $display("FAIL alu_op%0d acc=%h cy=%b z=%b required %h %b %b", i, acc, cy, z, ea[i], ec[i], ez[i]);
      end
    end
  endtask

  // ---------------------------------------------------------------
  task automatic test_jumps();
    int         cyc [10];
    logic [7:0] epc [10];
    clear_mem();
    mem[0]     = 8'h50; mem[1]     = 8'hFF;  // MVI A,FF
    mem[2]     = 8'h51; mem[3]     = 8'h01;  // ADI 1 -> 0, cy1 z1
    mem[4]     = 8'h5B; mem[5]     = 8'h10;  // JC 10   taken
    mem[8'h10] = 8'h5C; mem[8'h11] = 8'h20;  // JNC 20  not taken
    mem[8'h12] = 8'h59; mem[8'h13] = 8'h30;  // JZ 30   taken
    mem[8'h30] = 8'h5A; mem[8'h31] = 8'h40;  // JNZ 40  not taken
    mem[8'h32] = 8'h5D; mem[8'h33] = 8'h00;  // jump group r=5: NOP + imm
    mem[8'h34] = 8'h52; mem[8'h35] = 8'h00;  // imm group r=2: NOP + imm
    mem[8'h36] = 8'h58; mem[8'h37] = 8'hFE;  // JMP FE
    cyc = '{6, 3, 3, 3, 3, 3, 3, 3, 2, 2};
    epc = '{8'h04, 8'h10, 8'h12, 8'h30, 8'h32, 8'h34, 8'h36, 8'hFE, 8'hFF, 8'h00};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(cyc[i]);
      $display("[jmp] step %0d pc=%h acc=%h cy=%b z=%b", i, pc, acc, cy, z);
      checks++;
      if (pc !== epc[i] || acc !== 8'h00 || cy !== 1'b1 || z !== 1'b1) begin
        failures++;
        $display("FAIL jump_step%0d pc=%h acc=%h cy=%b z=%b required %h 00 1 1", i, pc, acc, cy, z, epc[i]);
      end
    end
  endtask

  // ---------------------------------------------------------------
  task automatic load_countdown();
    clear_mem();
    mem[0] = 8'h50; mem[1] = 8'h03;  // MVI A,3
    mem[2] = 8'h08;                  // MOV r0,A
    mem[3] = 8'h48;                  // DCR r0
    mem[4] = 8'h00;                  // MOV A,r0
    mem[5] = 8'h5A; mem[6] = 8'h02;  // JNZ 2
    mem[7] = 8'hF8;                  // HLT
  endtask

  task automatic test_countdown();
    load_countdown();
    do_reset();
    step(12);
    $display("[loop] first pass pc=%h acc=%h z=%b", pc, acc, z);
    checks++;
    if (pc !== 8'h02 || acc !== 8'h02 || z !== 1'b0) begin
      failures++;
      $display("FAIL loop_first pc=%h acc=%h z=%b required 02 02 0", pc, acc, z);
    end
    step(19);
    checks++;
    if (halted !== 1'b0) begin
      failures++;
      $display("FAIL loop_halt_early halted=%b required 0", halted);
    end
    step(1);
    $display("[loop] end pc=%h acc=%h cy=%b z=%b h=%b", pc, acc, cy, z, halted);
    checks++;
    if (halted !== 1'b1 || acc !== 8'h00 || z !== 1'b1 || cy !== 1'b0 || pc !== 8'h08) begin
      failures++;
      $display("FAIL loop_end h=%b acc=%h z=%b cy=%b pc=%h required 1 00 1 0 08", halted, acc, z, cy, pc);
    end
  endtask

  // ---------------------------------------------------------------
  task automatic test_stall();
    load_countdown();
    do_reset();
    step(10);
    checks++;
    if (pc !== 8'h06 || acc !== 8'h02 || z !== 1'b0) begin
      failures++;
      $display("FAIL stall_pre pc=%h acc=%h z=%b required 06 02 0", pc, acc, z);
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      $display("[stall] frozen cycle %0d pc=%h acc=%h z=%b", i, pc, acc, z);
      checks++;
      if (pc !== 8'h06 || acc !== 8'h02 || z !== 1'b0 || cy !== 1'b0 || halted !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold%0d pc=%h acc=%h z=%b cy=%b required 06 02 0 0", i, pc, acc, z, cy);
      end
    end
    en = 1'b1;
    step(21);
    checks++;
    if (halted !== 1'b0) begin
      failures++;
      $display("FAIL stall_halt_early halted=%b required 0", halted);
    end
    step(1);
    checks++;
    if (halted !== 1'b1 || acc !== 8'h00 || z !== 1'b1 || pc !== 8'h08) begin
      failures++;
      $display("FAIL stall_end h=%b acc=%h z=%b pc=%h required 1 00 1 08", halted, acc, z, pc);
    end
  endtask

  // ---------------------------------------------------------------
  task automatic test_wide();
    int waited;
    for (int i = 0; i < 1024; i++) mem2[i] = 8'h60;
    mem2[0] = 8'h50; mem2[1] = 8'hFF;   // MVI A,FF
    mem2[2] = 8'h51; mem2[3] = 8'h01;   // ADI 1 -> 0x0100, no carry at 16 bits
    mem2[4] = 8'h58; mem2[5] = 8'h80;   // JMP 80
    rst2 = 1'b1; en2 = 1'b1;
    step(1);
    rst2 = 1'b0;
    step(3);
    checks++;
    if (acc2 !== 16'h00FF) begin
      failures++;
      $display("FAIL wide_mvi acc=%h required 00ff", acc2);
    end
    step(3);
    $display("[wide] ADI acc=%h cy=%b z=%b", acc2, cy2, z2);
    checks++;
    if (acc2 !== 16'h0100 || cy2 !== 1'b0 || z2 !== 1'b0) begin
      failures++;
      $display("FAIL wide_adi acc=%h cy=%b z=%b required 0100 0 0", acc2, cy2, z2);
    end
    step(3);
    checks++;
    if (pc2 !== 10'h080) begin
      failures++;
      $display("FAIL wide_jmp pc=%h required 080", pc2);
    end
    waited = 0;
    while (pc2 !== 10'h3FF && waited < 4000) begin
      step(1);
      waited++;
    end
    checks++;
    if (pc2 !== 10'h3FF) begin
      failures++;
      $display("FAIL wide_reach_top pc=%h required 3ff (timeout)", pc2);
    end
    step(2);
    $display("[wide] after wrap pc=%h acc=%h", pc2, acc2);
    checks++;
    if (pc2 !== 10'h000 || acc2 !== 16'h0100 || halted2 !== 1'b0) begin
      failures++;
      $display("FAIL wide_wrap pc=%h acc=%h h=%b required 000 0100 0", pc2, acc2, halted2);
    end
  endtask

  initial begin
    rst  = 1'b1; en  = 1'b1;
    rst2 = 1'b1; en2 = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'h60;
    for (int i = 0; i < 1024; i++) mem2[i] = 8'h60;
    step(2);
    test_reset();
    test_add_chain();
    test_alu();
    test_jumps();
    test_countdown();
    test_stall();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
